traffic_gen_req_sched: RTL
==========================

Name: traffic_gen_req_sched

Overview:
Request scheduler for the traffic generator engine. It shares a single TCDM master port between the read-request stream (r_reqs) and the write-request stream (w_reqs) using round-robin arbitration. Traffic is paced in bursts of t_ck_reqs active cycles separated by t_ck_idle idle cycles, until n_total_reqs requests have been issued. It is started by the engine start pulse from the traffic_gen FSM and returns per-stream issue counters for its termination check.

Parameters:
ADDR_WIDTH, 32, TCDM address width
DATA_WIDTH, 32, TCDM write-data width
CNT_WIDTH, 32, width of all config values and counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous soft clear; same effect as rst_i
start_i  in  1  one-cycle start pulse
n_total_reqs_i  in  CNT_WIDTH  total requests to issue
t_ck_reqs_i  in  CNT_WIDTH  active (burst) window length in cycles
t_ck_idle_i  in  CNT_WIDTH  idle window length in cycles
r_valid_i  in  1  read requester valid
r_ready_o  out  1  read requester accepted
r_addr_i  in  ADDR_WIDTH  read address
w_valid_i  in  1  write requester valid
w_ready_o  out  1  write requester accepted
w_addr_i  in  ADDR_WIDTH  write address
w_data_i  in  DATA_WIDTH  write data
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_add_o  out  ADDR_WIDTH  TCDM address
tcdm_wen_o  out  1  1 = read, 0 = write
tcdm_data_o  out  DATA_WIDTH  TCDM write data
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle completion pulse
cnt_r_reqs_o  out  CNT_WIDTH  reads issued
cnt_w_reqs_o  out  CNT_WIDTH  writes issued

Behaviour:
- Reset and clear: rst_i has priority over clear_i. Either one forces state IDLE, zeroes all counters, sets last-grant to W (so R wins the first tie), and drives every output to 0. tcdm_wen_o is the exception and resets to 1.
- Configuration: on start_i in IDLE, latch n_total_reqs_i, t_ck_reqs_i and t_ck_idle_i, and zero cnt_r and cnt_w. Later config input changes are ignored until the next start. A latched t_ck_reqs of 0 is treated as 1.
- IDLE: start_i with n_total = 0 goes to DONE. start_i with n_total ≠ 0 goes to BURST with win_cnt = t_ck_reqs. start_i outside IDLE is ignored.
- BURST arbitration:
  - Only one stream valid: that stream is selected.
  - Both valid: select the stream opposite to last-grant.
  - tcdm_req_o = valid of the selected stream; address, wen and data are muxed combinationally from it.
- BURST handshake:
  - A handshake completes when tcdm_req_o & tcdm_gnt_i.
  - Handshake cycle: ready_o of the selected stream = 1, its counter increments, last-grant updates.
  - Stability: while tcdm_req_o = 1 and gnt = 0, the selection is locked; it does not switch even if the other stream becomes valid.
- BURST window:
  - win_cnt decrements every BURST cycle.
  - Window expires when win_cnt reaches 1 with no locked pending request: go to PAUSE with idle_cnt = t_ck_idle, or start a new BURST directly if t_ck_idle = 0.
  - A locked pending request extends the burst until it is granted.
- Completion: the handshake that makes cnt_r + cnt_w = n_total goes to DONE. That takes priority over window expiry. No further tcdm_req_o is raised from that handshake onward.
- PAUSE: tcdm_req_o = 0 and ready_o = 0. idle_cnt decrements; at 1, go to BURST with win_cnt reloaded.
- DONE: done_o = 1 for exactly one cycle, then IDLE. Counters hold their values until the next start.
- Latency: the first tcdm_req_o can assert in the cycle after start_i. ready_o is combinational on tcdm_gnt_i.
- Counter sizing: counters do not wrap before n_total because n_total fits in CNT_WIDTH.

Optional Feature:
TRAFFIC_GEN_REQ_SCHED_STALL_CNT_EN:
- Defined: adds output port stall_cnt_o (CNT_WIDTH). It counts cycles with tcdm_req_o = 1 and tcdm_gnt_i = 0, is zeroed on start, reset and clear, and holds its value after done.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Basic run: n_total = 4, t_ck_reqs = 8, t_ck_idle = 0, only r_valid = 1, gnt tied to 1 → 4 reads on cycles 1–4 after start; done_o pulses on cycle 5; cnt_r = 4, cnt_w = 0.
- Round-robin: both valid, gnt = 1, n_total = 6 → grant order R, W, R, W, R, W; cnt_r = 3, cnt_w = 3.
- Pacing: t_ck_reqs = 3, t_ck_idle = 2, r_valid = 1, n_total = 6 → tcdm_req_o pattern 1,1,1,0,0,1,1,1, then done.
- Grant stall: R pending with gnt low for 5 cycles while w_valid rises → address stays on R, no switch to W; burst extends past window end; with the macro defined, stall_cnt_o = 5.
- Zero total: start with n_total = 0 → no tcdm_req_o; done_o high on the cycle after start.
- Mid-run clear: pulse clear_i (then separately rst_i) during BURST after 2 grants → next cycle IDLE, counters 0, tcdm_req_o = 0, busy_o = 0, no done_o.

Source files
------------

// File: rtl/traffic_gen_req_sched.sv
// Round-robin read/write request scheduler onto one TCDM master port, paced in bursts.
// Optional `TRAFFIC_GEN_REQ_SCHED_STALL_CNT_EN adds stall_cnt_o (cycles with req high and no grant).
module traffic_gen_req_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  n_total_reqs_i,
  input  logic [CNT_WIDTH-1:0]  t_ck_reqs_i,
  input  logic [CNT_WIDTH-1:0]  t_ck_idle_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DATA_WIDTH-1:0] tcdm_data_o,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef TRAFFIC_GEN_REQ_SCHED_STALL_CNT_EN
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
`endif
  output logic [CNT_WIDTH-1:0]  cnt_r_reqs_o,
  output logic [CNT_WIDTH-1:0]  cnt_w_reqs_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] n_total, t_reqs, t_idle;
  logic [CNT_WIDTH-1:0] win_cnt, idle_cnt, cnt_r, cnt_w;
  logic                 last_w, locked, lock_w;

  logic in_burst, sel_w, req, hs, stall, last_req, win_end;

  // A request left ungranted keeps its stream selected until the grant arrives.
  always_comb begin
    in_burst = (state == BURST);
    if (locked)                  sel_w = lock_w;
    else if (r_valid_i & w_valid_i) sel_w = ~last_w;
    else                         sel_w = w_valid_i;
    req      = in_burst & (sel_w ? w_valid_i : r_valid_i);
    hs       = req & tcdm_gnt_i;
    stall    = req & ~tcdm_gnt_i;
    last_req = (cnt_r + cnt_w + CNT_WIDTH'(1)) == n_total;
    win_end  = win_cnt <= CNT_WIDTH'(1);
  end

  assign tcdm_req_o   = req;
  assign tcdm_add_o   = in_burst ? (sel_w ? w_addr_i : r_addr_i) : '0;
  assign tcdm_wen_o   = ~(in_burst & sel_w);
  assign tcdm_data_o  = (in_burst & sel_w) ? w_data_i : '0;
  assign r_ready_o    = hs & ~sel_w;
  assign w_ready_o    = hs & sel_w;
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign cnt_r_reqs_o = cnt_r;
  assign cnt_w_reqs_o = cnt_w;

`ifdef TRAFFIC_GEN_REQ_SCHED_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt;
  assign stall_cnt_o = stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)                stall_cnt <= '0;
    else if (state == IDLE && start_i)   stall_cnt <= '0;
    else if (stall)                      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state    <= IDLE;
      n_total  <= '0;
      t_reqs   <= '0;
      t_idle   <= '0;
      win_cnt  <= '0;
      idle_cnt <= '0;
      cnt_r    <= '0;
      cnt_w    <= '0;
      last_w   <= 1'b1;
      locked   <= 1'b0;
      lock_w   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          n_total <= n_total_reqs_i;
          t_reqs  <= (t_ck_reqs_i == '0) ? CNT_WIDTH'(1) : t_ck_reqs_i;
          win_cnt <= (t_ck_reqs_i == '0) ? CNT_WIDTH'(1) : t_ck_reqs_i;
          t_idle  <= t_ck_idle_i;
          cnt_r   <= '0;
          cnt_w   <= '0;
          locked  <= 1'b0;
          state   <= (n_total_reqs_i == '0) ? DONE : BURST;
        end
        BURST: begin
          locked <= stall;
          lock_w <= sel_w;
          if (!win_end) win_cnt <= win_cnt - CNT_WIDTH'(1);
          if (hs) begin
            last_w <= sel_w;
            if (sel_w) cnt_w <= cnt_w + CNT_WIDTH'(1);
            else       cnt_r <= cnt_r + CNT_WIDTH'(1);
          end
          // Completion wins over window expiry; a stalled request holds the window open.
          if (hs && last_req) begin
            state <= DONE;
          end else if (win_end && !stall) begin
            if (t_idle == '0) begin
              win_cnt <= t_reqs;
            end else begin
              idle_cnt <= t_idle;
              state    <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (idle_cnt <= CNT_WIDTH'(1)) begin
            win_cnt <= t_reqs;
            state   <= BURST;
          end else begin
            idle_cnt <= idle_cnt - CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
